clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Counter-based multi-channel clock-enable generator. Replaces the fixed single-output
//  MMCM divider wherever fabric logic needs slower rates. Each of NUM_CH channels divides
//  clk by a runtime-programmable ratio and emits a one-cycle tick plus a divided level.
//  Outputs are enables/levels for logic on clk. They are never used as clocks.
// PARAMETERS
//  NUM_CH   4    number of independent channels (>=1)
//  DIV_W    8    width of divide ratio and counters
//  DEF_DIV  20   ratio loaded into every channel at reset (100 MHz -> 5 MHz)
// PORTS
//  clk        in   1                 system clock
//  rst_n      in   1                 async active-low reset
//  en         in   1                 global run enable
//  cfg_valid  in   1                 ratio write request
//  cfg_ready  out  1                 write accepted when cfg_valid&cfg_ready at clk edge
//  cfg_ch     in   CH_W              target channel, CH_W = max(1,$clog2(NUM_CH))
//  cfg_div    in   DIV_W             new ratio N; 0 = channel stopped
//  tick       out  NUM_CH            1-cycle pulse, once per N cycles per channel
//  clk_out    out  NUM_CH            divided level, high for ceil(N/2) of N cycles
//  locked     out  NUM_CH            channel has completed one full period at current N
// BEHAVIOUR
//  - Reset: active_div=DEF_DIV, cnt=0, run=0, pending=0.
//    tick, clk_out and locked are all 0. cfg_ready=1.
//  - run is a registered copy of en. While run=0: cnt held at 0 and tick/clk_out/locked=0.
//  - While run=1 and active_div!=0:
//    - cnt counts 0..N-1 and wraps.
//    - tick = (cnt==0); clk_out = (cnt < (N+1)>>1). Both are decoded from registers.
//    - First tick occurs in the cycle after the first edge that samples en=1.
//    - Tick period is exactly N cycles. N=1 gives tick every cycle and clk_out constant 1.
//  - active_div==0: the channel behaves as if run=0.
//  - Config handshake:
//    - cfg_ready = ~pending[cfg_ch] (combinational).
//    - An accepted write stores cfg_div into shadow[cfg_ch] and sets pending.
//    - cfg_ch>=NUM_CH: the write is accepted and dropped.
//  - Apply: shadow->active_div, cnt->0, locked->0, pending->0. Apply occurs:
//    - at the boundary edge (cnt==N-1) while running, so no runt period is emitted; or
//    - at the next edge if the channel is stopped (run=0 or active_div==0).
//  - locked sets on the wrap back to cnt==0 that follows a complete N-cycle period after
//    an apply or a run start. It clears on apply, on en low, or on N=0.
//  - en falling: the edge that samples en=0 clears run. Outputs go 0 in the next cycle;
//    a partial period is abandoned.
//  - Simultaneous apply and en falling: the apply takes effect and the channel stops.
//  - Reset asserted mid-operation returns every register to its reset value
//    asynchronously, including discarding any pending write.
// CONFIGURATION
//  CLKDIV_PHASE_EN defined:
//   - Adds input cfg_phase [DIV_W-1:0], captured into the shadow alongside cfg_div.
//   - On apply, cnt loads cfg_phase if cfg_phase < N, else 0.
//   - locked counts from the first natural wrap after the apply.
//  CLKDIV_PHASE_EN undefined: port absent; apply always loads cnt=0.
// STRUCTURE
//  - Package clk_div_pkg:
//    - DIV_W_DEF and DEF_DIV_DEF constants.
//    - ch_w(n) function returning max(1,$clog2(n)).
//    - typedef div_t = logic [DIV_W-1:0].
//  - Sub-module clk_div_ch: one channel holding cnt, active_div, shadow, pending and
//    locked. Instantiated NUM_CH times via generate. The top handles decode and cfg_ready.
// TESTING
//  1 Reset release, en=1, default N=20: tick every 20 cycles; clk_out 10 high / 10 low;
//    locked rises at the 2nd tick.
//  2 Write ch1 N=7 mid-period: old 20-cycle period completes intact, then 7-cycle ticks;
//    clk_out 4 high / 3 low; locked drops at the apply and re-rises one period later.
//  3 Two back-to-back writes to the same channel: cfg_ready low until apply; second write
//    stalls, then applies at the following boundary. Other channels are unaffected.
//  4 N=1 on ch0: tick and clk_out constantly 1. N=0: all ch0 outputs 0. Rewrite N=3:
//    applies on the next edge.
//  5 en low for 5 cycles mid-period: outputs 0 one cycle later. en high again: first tick
//    one cycle after sampling, full-period counts resume from 0. Then assert rst_n
//    mid-period: all outputs 0 immediately.
//  6 CLKDIV_PHASE_EN with N=10, phase=4: first tick 6 cycles after apply. With phase=12:
//    behaves as phase 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, ratio type and channel-index width helper for clk_div_multi
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int DEF_DIV_DEF = 20;
  typedef logic [DIV_W_DEF-1:0] div_t;
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: run enable, ratio write handshake and per-channel outputs of clk_div_multi
// CLKDIV_PHASE_EN adds cfg_phase
interface clk_div_multi_if import clk_div_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DIV_W_DEF
);
  localparam int CH_W = ch_w(NUM_CH);
  logic en, cfg_valid, cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] cfg_phase;
`endif
  logic [NUM_CH-1:0] tick, clk_out, locked;
  modport master (
    output en, cfg_valid, cfg_ch, cfg_div,
`ifdef CLKDIV_PHASE_EN
    cfg_phase,
`endif
    input cfg_ready, tick, clk_out, locked
  );
  modport slave (
    input en, cfg_valid, cfg_ch, cfg_div,
`ifdef CLKDIV_PHASE_EN
    cfg_phase,
`endif
    output cfg_ready, tick, clk_out, locked
  );
endinterface

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel; new ratios wait in a shadow until the period boundary
// CLKDIV_PHASE_EN adds a start phase loaded into the counter on apply
module clk_div_ch import clk_div_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic wr_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0] phase_i,
`endif
  output logic tick_o,
  output logic clk_out_o,
  output logic locked_o,
  output logic pend_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, sh_q, sh_d, ld, half;
  logic pend_q, pend_d, lock_q, lock_d, active, wrap, apply, arm;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] ph_q;
  logic arm_q;
  assign ld = ph_q < sh_q ? ph_q : '0;
  assign arm = arm_q;
  // arm marks that the counter is period-aligned, so the next wrap closes a full period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph_q <= '0;
      arm_q <= 1'b1;
    end else begin
      if (wr_i) ph_q <= phase_i;
      arm_q <= apply ? ld == '0 : !active || arm_q || wrap;
    end
`else
  assign ld = '0;
  assign arm = 1'b1;
`endif
  always_comb begin
    active = run_i && div_q != '0;
    wrap = active && cnt_q == div_q - DIV_W'(1);
    apply = pend_q && (wrap || !active);
    cnt_d = apply ? ld : (wrap || !active) ? '0 : cnt_q + DIV_W'(1);
    div_d = apply ? sh_q : div_q;
    sh_d = wr_i ? div_i : sh_q;
    pend_d = wr_i || (pend_q && !apply);
    lock_d = !apply && active && (lock_q || (wrap && arm));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DEF_DIV);
      sh_q <= DIV_W'(DEF_DIV);
      pend_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      sh_q <= sh_d;
      pend_q <= pend_d;
      lock_q <= lock_d;
    end
  // widened so N at full scale does not overflow the ceil(N/2) threshold
  assign half = DIV_W'(({1'b0, div_q} + (DIV_W+1)'(1)) >> 1);
  assign tick_o = active && cnt_q == '0;
  assign clk_out_o = active && cnt_q < half;
  assign locked_o = lock_q && active;
  assign pend_o = pend_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH runtime-programmable clock-enable dividers behind a valid/ready ratio port
// CLKDIV_PHASE_EN adds a per-write start phase
module clk_div_multi import clk_div_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input logic clk,
  input logic rst_n,
  clk_div_multi_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int PW = 1 << CH_W;
  logic run_q;
  logic [NUM_CH-1:0] pend;
  logic [PW-1:0] pend_x;
  // out-of-range channels read as never pending, so their writes are accepted and dropped
  assign pend_x = PW'(pend);
  assign bus.cfg_ready = ~pend_x[bus.cfg_ch];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_q <= 1'b0;
    else run_q <= bus.en;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .run_i(run_q),
      .wr_i(bus.cfg_valid && bus.cfg_ready && bus.cfg_ch == CH_W'(i)),
      .div_i(bus.cfg_div),
`ifdef CLKDIV_PHASE_EN
      .phase_i(bus.cfg_phase),
`endif
      .tick_o(bus.tick[i]),
      .clk_out_o(bus.clk_out[i]),
      .locked_o(bus.locked[i]),
      .pend_o(pend[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus checked against a period-level model
module tb_clk_div_multi;
  import clk_div_pkg::*;
  localparam int NC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int m_div[NC], m_sh[NC], m_psh[NC], m_age[NC], m_done[NC];
  bit m_pend[NC];
  bit m_run;

  clk_div_multi_if #(.NUM_CH(NC), .DIV_W(DIV_W_DEF)) bus();
  clk_div_multi #(.NUM_CH(NC), .DIV_W(DIV_W_DEF), .DEF_DIV(DEF_DIV_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // model: m_age = cycles elapsed in the current period, m_done = full periods completed
  function automatic void m_reset();
    m_run = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_div[c] = DEF_DIV_DEF;
      m_sh[c] = DEF_DIV_DEF;
      m_psh[c] = 0;
      m_age[c] = 0;
      m_done[c] = 0;
      m_pend[c] = 1'b0;
    end
  endfunction

  function automatic void m_edge();
    bit acc;
    int wc;
    wc = int'(bus.cfg_ch);
    acc = bus.cfg_valid && !m_pend[wc];
    for (int c = 0; c < NC; c++) begin
      bit live, last;
      live = m_run && m_div[c] != 0;
      last = live && m_age[c] == m_div[c] - 1;
      if (m_pend[c] && (last || !live)) begin
        m_div[c] = m_sh[c];
        m_age[c] = m_psh[c] < m_sh[c] ? m_psh[c] : 0;
        m_done[c] = m_age[c] == 0 ? 0 : -1;
        m_pend[c] = 1'b0;
      end else if (!live) begin
        m_age[c] = 0;
        m_done[c] = 0;
      end else if (last) begin
        m_age[c] = 0;
        m_done[c]++;
      end else m_age[c]++;
    end
    if (acc) begin
      m_sh[wc] = int'(bus.cfg_div);
`ifdef CLKDIV_PHASE_EN
      m_psh[wc] = int'(bus.cfg_phase);
`else
      m_psh[wc] = 0;
`endif
      m_pend[wc] = 1'b1;
    end
    m_run = bus.en;
  endfunction

  task automatic check();
    logic [NC-1:0] et, eo, el;
    logic er;
    for (int c = 0; c < NC; c++) begin
      bit live;
      live = m_run && m_div[c] != 0;
      et[c] = live && m_age[c] == 0;
      eo[c] = live && m_age[c] < (m_div[c] + 1) / 2;
      el[c] = live && m_done[c] >= 1;
    end
    er = !m_pend[int'(bus.cfg_ch)];
    n_chk++;
    assert (bus.tick === et) else begin n_err++; $error("FAIL tick got %b exp %b at %0t", bus.tick, et, $time); end
    n_chk++;
    assert (bus.clk_out === eo) else begin n_err++; $error("FAIL clk_out got %b exp %b at %0t", bus.clk_out, eo, $time); end
    n_chk++;
    assert (bus.locked === el) else begin n_err++; $error("FAIL locked got %b exp %b at %0t", bus.locked, el, $time); end
    n_chk++;
    assert (bus.cfg_ready === er) else begin n_err++; $error("FAIL cfg_ready got %b exp %b at %0t", bus.cfg_ready, er, $time); end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      @(negedge clk);
      check();
    end
  endtask

  task automatic wr(input logic [1:0] ch, input div_t dv, input div_t ph);
    bit ok;
    ok = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = ch;
    bus.cfg_div = dv;
`ifdef CLKDIV_PHASE_EN
    bus.cfg_phase = ph;
`else
    if (ph != '0) $display("note: phase %0d ignored in this build", ph);
`endif
    for (int k = 0; k < 600 && !ok; k++) begin
      ok = !m_pend[int'(ch)];
      step();
    end
    bus.cfg_valid = 1'b0;
    n_chk++;
    assert (ok) else begin n_err++; $error("FAIL wr_accept ch%0d got stalled exp accepted", ch); end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_div = '0;
`ifdef CLKDIV_PHASE_EN
    bus.cfg_phase = '0;
`endif
    m_reset();
    @(negedge clk);
    check();
    rst_n = 1'b1;
    step(2);
    bus.en = 1'b1;
    step(45);
    wr(2'd1, 8'd7, 8'd0);
    step(50);
    wr(2'd2, 8'd5, 8'd0);
    wr(2'd2, 8'd9, 8'd0);
    step(40);
    wr(2'd0, 8'd1, 8'd0);
    step(8);
    wr(2'd0, 8'd0, 8'd0);
    step(5);
    wr(2'd0, 8'd3, 8'd0);
    step(10);
    step(7);
    bus.en = 1'b0;
    step(5);
    bus.en = 1'b1;
    step(30);
    wr(2'd3, 8'd4, 8'd0);
    step(3);
    @(posedge clk);
    m_edge();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    n_chk++;
    assert (bus.tick === '0 && bus.clk_out === '0 && bus.locked === '0 && bus.cfg_ready === 1'b1)
      else begin n_err++; $error("FAIL async_rst got %b/%b/%b/%b exp 0/0/0/1", bus.tick, bus.clk_out, bus.locked, bus.cfg_ready); end
    @(negedge clk);
    check();
    rst_n = 1'b1;
    step(45);
    wr(2'd3, 8'd255, 8'd0);
    step(530);
`ifdef CLKDIV_PHASE_EN
    wr(2'd3, 8'd10, 8'd4);
    step(25);
    wr(2'd3, 8'd10, 8'd12);
    step(25);
`endif
    repeat (400) begin
      bus.en = $urandom_range(0, 15) != 0;
      bus.cfg_valid = $urandom_range(0, 3) == 0;
      bus.cfg_ch = 2'($urandom_range(0, 3));
      bus.cfg_div = 8'($urandom_range(0, 12));
`ifdef CLKDIV_PHASE_EN
      bus.cfg_phase = 8'($urandom_range(0, 14));
`endif
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
